// File: rtl/ucomb_pkg.sv
// rtl/ucomb_pkg.sv - shared state type, widths and stimulus field map for the ucomb scan driver
package ucomb_pkg;

  localparam int UCOMB_IN_W  = 27;
  localparam int UCOMB_OUT_W = 6;

  localparam int UCOMB_U21_OFS = 0;
  localparam int UCOMB_U31_OFS = 4;
  localparam int UCOMB_U41_OFS = 10;
  localparam int UCOMB_U22_OFS = 20;
  localparam int UCOMB_SEL_OFS = 26;

  // Reference-path vector: u21 inputs 4'b0011 with the select bit steering to the reference side.
  localparam logic [UCOMB_IN_W-1:0] UCOMB_REFMODE = 27'h4000003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_APPLY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_DONE
  } ucomb_state_e;

  function automatic int ucomb_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ucomb_shift_reg.sv
// rtl/ucomb_shift_reg.sv - LSB-first load/shift register with synchronous clear
module ucomb_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [W-1:0] pdata,
  output logic [W-1:0] q
);

  // New bits enter at the MSB so the first serial bit ends up in q[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= pdata;
    end else if (shift) begin
      q <= {sin, q[W-1:1]};
    end
  end

endmodule

// File: rtl/ucomb_scan_driver.sv
// rtl/ucomb_scan_driver.sv - serial stimulus in, atomic apply, settle, capture, serial result out
module ucomb_scan_driver
  import ucomb_pkg::*;
#(
  parameter int IN_W   = UCOMB_IN_W,
  parameter int OUT_W  = UCOMB_OUT_W,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             sdi,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(ucomb_max3(IN_W, OUT_W, SETTLE) + 1);

  ucomb_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  shadow;
  logic [OUT_W-1:0] capture;
  logic             sh_shift;
  logic             cap_load;
  logic             cap_shift;

  // Abort freezes capture but wipes the partially shifted stimulus.
  always_comb begin
    sh_shift  = 1'b0;
    cap_load  = 1'b0;
    cap_shift = 1'b0;
    if (!abort) begin
      sh_shift  = (state == ST_SHIFT_IN);
      cap_load  = (state == ST_CAPTURE);
      cap_shift = (state == ST_SHIFT_OUT);
    end
  end

  ucomb_shift_reg #(.W(IN_W)) u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .load  (1'b0),
    .shift (sh_shift),
    .sin   (sdi),
    .pdata ('0),
    .q     (shadow)
  );

  ucomb_shift_reg #(.W(OUT_W)) u_capture (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .load  (cap_load),
    .shift (cap_shift),
    .sin   (1'b0),
    .pdata (dut_out),
    .q     (capture)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dut_in    <= '0;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sdo_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT_IN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT_IN: begin
          if (cnt == CNT_W'(IN_W - 1)) begin
            state <= ST_APPLY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_APPLY: begin
          dut_in <= shadow;
          state  <= ST_SETTLE;
          cnt    <= '0;
        end
        ST_SETTLE: begin
          if (cnt == CNT_W'(SETTLE - 1)) begin
            state <= ST_CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          state <= ST_SHIFT_OUT;
          cnt   <= '0;
        end
        ST_SHIFT_OUT: begin
          // capture shifts right in step, so bit 0 is always the next result bit
          sdo       <= capture[0];
          sdo_valid <= 1'b1;
          if (cnt == CNT_W'(OUT_W - 1)) begin
            state <= ST_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          sdo       <= 1'b0;
          sdo_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucomb_scan_driver.sv
// tb/tb_ucomb_scan_driver.sv - directed bench driving SETTLE=2, 1 and 15 builds side by side
module tb_ucomb_scan_driver;
  import ucomb_pkg::*;

  localparam int IN_W  = 27;
  localparam int OUT_W = 6;
  localparam int NI    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sdi = 1'b0;

  logic [IN_W-1:0]  din  [NI];
  logic [OUT_W-1:0] dout [NI];
  logic [NI-1:0]    sdo_b, sv_b, busy_b, done_b;

  int total = 0;
  int bad = 0;

  logic [OUT_W-1:0] r_res [NI];
  int r_first [NI];
  int r_done [NI];
  int r_bits [NI];
  int r_dpulses [NI];
  int r_hold_bad;
  int r_apply;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_model
    assign dout[g] = din[g][5:0] ^ din[g][UCOMB_SEL_OFS -: 6];
  end

  ucomb_scan_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sdi(sdi),
    .dut_in(din[0]), .dut_out(dout[0]), .sdo(sdo_b[0]), .sdo_valid(sv_b[0]),
    .busy(busy_b[0]), .done(done_b[0])
  );

  ucomb_scan_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sdi(sdi),
    .dut_in(din[1]), .dut_out(dout[1]), .sdo(sdo_b[1]), .sdo_valid(sv_b[1]),
    .busy(busy_b[1]), .done(done_b[1])
  );

  ucomb_scan_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(15)) u_dut_s15 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sdi(sdi),
    .dut_in(din[2]), .dut_out(dout[2]), .sdo(sdo_b[2]), .sdo_valid(sv_b[2]),
    .busy(busy_b[2]), .done(done_b[2])
  );

  function automatic int settle_of(input int j);
    case (j)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // One full transaction; n counts rising edges after the start edge E0.
  task automatic do_txn(input logic [IN_W-1:0] vec, input logic [IN_W-1:0] hold_exp, input bit pulse);
    int n;
    for (int j = 0; j < NI; j++) begin
      r_res[j] = '0; r_first[j] = -1; r_done[j] = -1; r_bits[j] = 0; r_dpulses[j] = 0;
    end
    r_hold_bad = 0;
    r_apply = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    for (int i = 0; i < IN_W; i++) begin
      sdi = vec[i];
      if (pulse && i == 10) start = 1'b1;
      @(negedge clk); start = 1'b0; n++;
      if (din[0] !== hold_exp) r_hold_bad++;
    end
    sdi = 1'b0;
    for (int c = 0; c < 34; c++) begin
      if (pulse && r_bits[0] == 2) start = 1'b1;
      @(negedge clk); start = 1'b0; n++;
      if (r_apply < 0 && din[0] === vec) r_apply = n;
      for (int j = 0; j < NI; j++) begin
        if (sv_b[j]) begin
          if (r_first[j] < 0) r_first[j] = n;
          if (r_bits[j] < OUT_W) r_res[j][r_bits[j]] = sdo_b[j];
          r_bits[j]++;
        end
        if (done_b[j]) begin
          if (r_done[j] < 0) r_done[j] = n;
          r_dpulses[j]++;
        end
      end
    end
  endtask

  task automatic test_reset;
    int viol;
    repeat (2) @(negedge clk);
    total++;
    if (din[0] !== '0 || sv_b !== '0 || busy_b !== '0 || done_b !== '0 || sdo_b !== '0) begin
      bad++;
      $display("FAIL reset_values din=%h sv=%b busy=%b done=%b sdo=%b required all zero", din[0], sv_b, busy_b, done_b, sdo_b);
    end
    rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (din[0] !== '0 || sv_b !== '0 || busy_b !== '0 || done_b !== '0) begin
        bad++; viol++;
        $display("FAIL idle_quiet cycle=%0d din=%h sv=%b busy=%b done=%b required zero", i, din[0], sv_b, busy_b, done_b);
      end
    end
  endtask

  task automatic test_refmode;
    do_txn(UCOMB_REFMODE, '0, 1'b0);
    total++; if (r_res[0] !== 6'h23) begin bad++; $display("FAIL refmode_result got=%h exp=23", r_res[0]); end
    total++; if (r_hold_bad != 0) begin bad++; $display("FAIL refmode_hold changes=%0d exp=0", r_hold_bad); end
    total++; if (r_apply != IN_W + 1) begin bad++; $display("FAIL refmode_apply_edge got=%0d exp=%0d", r_apply, IN_W + 1); end
    total++; if (r_first[0] != IN_W + 2 + 3) begin bad++; $display("FAIL refmode_first_valid got=%0d exp=%0d", r_first[0], IN_W + 5); end
    total++; if (r_done[0] != 38) begin bad++; $display("FAIL refmode_done_edge got=%0d exp=38", r_done[0]); end
    total++; if (r_bits[0] != OUT_W || r_dpulses[0] != 1) begin
      bad++; $display("FAIL refmode_counts bits=%0d pulses=%0d exp 6 and 1", r_bits[0], r_dpulses[0]);
    end
    total++; if (din[0] !== UCOMB_REFMODE) begin bad++; $display("FAIL refmode_persist got=%h exp=%h", din[0], UCOMB_REFMODE); end
  endtask

  task automatic test_back_to_back;
    do_txn(27'h7FFFFFF, UCOMB_REFMODE, 1'b0);
    total++; if (r_res[0] !== 6'h00) begin bad++; $display("FAIL ones_result got=%h exp=00", r_res[0]); end
    do_txn(27'h0000000, 27'h7FFFFFF, 1'b0);
    total++; if (r_res[0] !== 6'h00) begin bad++; $display("FAIL zeros_result got=%h exp=00", r_res[0]); end
    total++; if (r_hold_bad != 0) begin bad++; $display("FAIL ones_hold changes=%0d exp=0", r_hold_bad); end
    total++; if (din[0] !== 27'h0) begin bad++; $display("FAIL zeros_applied got=%h exp=0", din[0]); end
  endtask

  task automatic test_start_ignored;
    do_txn(27'h5A5A5A5, 27'h0, 1'b1);
    total++; if (r_res[0] !== 6'h08) begin bad++; $display("FAIL busy_start_result got=%h exp=08", r_res[0]); end
    total++; if (r_done[0] != 38) begin bad++; $display("FAIL busy_start_done_edge got=%0d exp=38", r_done[0]); end
    total++; if (r_bits[0] != OUT_W || r_dpulses[0] != 1) begin
      bad++; $display("FAIL busy_start_counts bits=%0d pulses=%0d exp 6 and 1", r_bits[0], r_dpulses[0]);
    end
    total++; if (busy_b !== '0) begin bad++; $display("FAIL busy_start_idle busy=%b exp=000", busy_b); end
  endtask

  task automatic test_abort;
    logic [IN_W-1:0] v;
    int dseen;
    v = 27'h0000015;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      sdi = v[i];
      @(negedge clk);
    end
    sdi = 1'b0;
    @(negedge clk);
    total++; if (din[0] !== v) begin bad++; $display("FAIL abort_applied got=%h exp=%h", din[0], v); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++; if (busy_b !== '0 || sv_b !== '0 || done_b !== '0) begin
      bad++; $display("FAIL abort_idle busy=%b sv=%b done=%b exp all zero", busy_b, sv_b, done_b);
    end
    total++; if (din[0] !== v) begin bad++; $display("FAIL abort_dut_in got=%h exp=%h", din[0], v); end
    dseen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_b !== '0) dseen++;
    end
    total++; if (dseen != 0) begin bad++; $display("FAIL abort_no_done pulses=%0d exp=0", dseen); end
    do_txn(27'h1234567, v, 1'b0);
    total++; if (r_res[0] !== 6'h2E) begin bad++; $display("FAIL after_abort_result got=%h exp=2e", r_res[0]); end
    total++; if (r_done[0] != 38) begin bad++; $display("FAIL after_abort_done_edge got=%0d exp=38", r_done[0]); end
  endtask

  task automatic test_reset_mid;
    logic [IN_W-1:0] v;
    int nb;
    int c;
    v = 27'h000003F;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      sdi = v[i];
      @(negedge clk);
    end
    sdi = 1'b0;
    nb = 0;
    c = 0;
    while (nb < 3 && c < 40) begin
      @(negedge clk); c++;
      if (sv_b[0]) nb++;
    end
    total++; if (nb != 3 || sdo_b[0] !== 1'b1) begin
      bad++; $display("FAIL midout_reach bits=%0d sdo=%b exp 3 and 1", nb, sdo_b[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (sdo_b !== '0 || sv_b !== '0 || busy_b !== '0 || done_b !== '0 || din[0] !== '0) begin
      bad++; $display("FAIL async_reset sdo=%b sv=%b busy=%b done=%b din=%h exp all zero", sdo_b, sv_b, busy_b, done_b, din[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    do_txn(UCOMB_REFMODE, '0, 1'b0);
    for (int j = 0; j < NI; j++) begin
      total++; if (r_res[j] !== 6'h23) begin bad++; $display("FAIL rerun_result inst=%0d got=%h exp=23", j, r_res[j]); end
      total++; if (r_first[j] != IN_W + settle_of(j) + 3) begin
        bad++; $display("FAIL rerun_first_valid inst=%0d got=%0d exp=%0d", j, r_first[j], IN_W + settle_of(j) + 3);
      end
      total++; if (r_done[j] != IN_W + settle_of(j) + 3 + OUT_W + 3 - 3) begin
        bad++; $display("FAIL rerun_done_edge inst=%0d got=%0d exp=%0d", j, r_done[j], IN_W + settle_of(j) + OUT_W + 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_refmode();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ucomb_scan_driver.md
Name: ucomb_scan_driver

Overview:
- Serial-to-parallel test driver for the universal-gate combinational test wrapper (27-bit stimulus in, 6-bit result out).
- Shifts a 27-bit stimulus vector in over one serial pin and applies it atomically to the wrapper's input bus.
- Waits a programmable settle time, captures the wrapper's 6-bit result and shifts it back out serially.
- Lets the pin-limited top level exercise both the gate path and the reference path (refmode vectors) with three pins.

Parameters:
- IN_W, 27, width of the stimulus vector driven to the wrapper.
- OUT_W, 6, width of the result vector captured from the wrapper.
- SETTLE, 2, cycles between applying dut_in and capturing dut_out; legal range 1..15.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a transaction; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- sdi  input  1  serial stimulus, LSB first.
- dut_in  output  IN_W  applied stimulus to the wrapper; registered.
- dut_out  input  OUT_W  wrapper result; combinational from dut_in.
- sdo  output  1  serial result, LSB first; registered.
- sdo_valid  output  1  high while sdo carries a result bit.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at transaction end.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; dut_in=0, shadow=0, capture=0, sdo=0, sdo_valid=0, busy=0, done=0, counters=0.
- FSM states: IDLE, SHIFT_IN, APPLY, SETTLE, CAPTURE, SHIFT_OUT, DONE.
- IDLE: if start=1 at edge E0, go to SHIFT_IN with bit counter=0; sdi at E0 is not sampled.
- SHIFT_IN: at each of edges E1..E_IN_W, shadow <= {sdi, shadow[IN_W-1:1]}, so the first bit ends at shadow[0]. After IN_W bits, go to APPLY.
- Shadow-register rule: dut_in does not change during SHIFT_IN; it holds the previously applied vector.
- APPLY: one edge; dut_in <= shadow (all bits in the same cycle, no glitch across fields). Go to SETTLE with counter=0.
- SETTLE: count SETTLE edges, then go to CAPTURE.
- CAPTURE: capture <= dut_out. dut_out is therefore sampled after dut_in has been stable for SETTLE+1 edges. Go to SHIFT_OUT.
- SHIFT_OUT: for OUT_W cycles, sdo=capture[k] and sdo_valid=1 for k=0..OUT_W-1, each driven from a register; then go to DONE.
- DONE: done=1 for exactly one cycle, sdo_valid=0, then IDLE.
- Latency: start edge to first sdo_valid cycle is IN_W+SETTLE+3 edges. For defaults, done is asserted 27+1+2+1+6+1 = 38 edges after E0.
- dut_in persists after DONE and after abort until the next APPLY or reset.
- start while busy: ignored. A start asserted in the DONE cycle is also ignored; a new transaction needs start in IDLE.
- abort: has priority over every other transition. The next state is IDLE; sdo_valid=0; done is not pulsed; shadow and counters are cleared; dut_in and capture are unchanged.
- abort and start asserted together in IDLE: stay in IDLE.
- Reset mid-transaction: all outputs return to reset values immediately (async), including dut_in=0.
- Counter width: $clog2(max(IN_W,OUT_W,SETTLE)+1). No counter wraps; each is cleared on state entry.

Decomposition:
- Shared package ucomb_pkg holds:
  - the state enum;
  - UCOMB_IN_W=27 and UCOMB_OUT_W=6;
  - field offsets of the stimulus vector (u21 0, u31 4, u41 10, u22 20, sel 26);
  - the refmode pattern constant (bits[3:0]=4'b0011, bit26=1).
- One natural sub-module, ucomb_shift_reg: a parameterised width, LSB-first, load/shift register with clear. It is instantiated twice: for the shadow (serial-in) and for the capture (parallel-load, serial-out).

Test Plan (bench model: dut_out = dut_in[5:0] ^ dut_in[26:21], combinational):
- Reset then idle 10 cycles -> dut_in=0, sdo_valid=0, busy=0, done=0 throughout.
- Shift vector 27'h4000003 (refmode) -> dut_in changes only at the APPLY edge. sdo stream LSB first = 6'h23. done pulses 38 edges after start.
- Shift 27'h7FFFFFF, then 27'h0000000 -> results 6'h00 and 6'h00. dut_in holds 27'h7FFFFFF during the entire second SHIFT_IN.
- Pulse start during SHIFT_IN and during SHIFT_OUT -> no restart; bit and cycle counts are unchanged.
- abort in SETTLE after applying 27'h0000015 -> IDLE next cycle, no done pulse, dut_in=27'h0000015. Next transaction runs normally.
- Deassert rst_n mid-SHIFT_OUT -> sdo, sdo_valid, busy and dut_in go to 0 without a clock edge. Re-run completes correctly with SETTLE=1 and SETTLE=15 builds.
